// File: rtl/audio_gain_sequencer_pkg.sv
// audio_pkg: shared constants, FSM state type and saturation helper for the audio gain sequencer
package audio_pkg;
   localparam int SAMPLE_W = 24;
   localparam int GAIN_W = 8;
   localparam int GAIN_SHIFT = 7;
   localparam int UNITY_GAIN = 1 << GAIN_SHIFT;
   localparam int SAMPLE_MAX = (1 << (SAMPLE_W - 1)) - 1;
   localparam int SAMPLE_MIN = -(1 << (SAMPLE_W - 1));
   typedef enum logic [2:0] {IDLE, READ, MUL, SAT, WRITE} seq_state_t;
   // returns {clip, sample}: arithmetic shift (floor) then clamp to the sample range
   function automatic logic [SAMPLE_W:0] saturate(input logic signed [SAMPLE_W+GAIN_W-1:0] acc);
      logic signed [SAMPLE_W+GAIN_W-1:0] v;
      v = acc >>> GAIN_SHIFT;
      return v > SAMPLE_MAX ? {1'b1, SAMPLE_W'(SAMPLE_MAX)} :
             v < SAMPLE_MIN ? {1'b1, SAMPLE_W'(SAMPLE_MIN)} : {1'b0, v[SAMPLE_W-1:0]};
   endfunction
endpackage

// File: rtl/audio_gain_sequencer_if.sv
// audio_gain_sequencer_if: codec sample handshake
//   master (sequencer): in read_ready, write_ready, readdata_*; out read, write, writedata_*
//   slave  (codec)    : the mirror image
interface audio_gain_sequencer_if #(parameter int SAMPLE_W = audio_pkg::SAMPLE_W);
   logic read_ready, write_ready, read, write;
   logic [SAMPLE_W-1:0] readdata_left, readdata_right, writedata_left, writedata_right;
   modport master(input read_ready, write_ready, readdata_left, readdata_right,
                  output read, write, writedata_left, writedata_right);
   modport slave(output read_ready, write_ready, readdata_left, readdata_right,
                 input read, write, writedata_left, writedata_right);
endinterface

// File: rtl/audio_gain_sequencer_seq_mult.sv
// seq_mult: serial signed(A_W) x unsigned(B_W) shift-add multiplier, one multiplier bit per step
//   start loads a and clears p; step adds a<<bit_idx when b[bit_idx]; done on the last step
//   bit_idx is the caller's iteration counter so several instances stay in lockstep
module seq_mult #(
   parameter int A_W = 24,
   parameter int B_W = 8,
   localparam int C_W = $clog2(B_W),
   localparam int P_W = A_W + B_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  step,
   input  logic [C_W-1:0]        bit_idx,
   input  logic [A_W-1:0]        a,
   input  logic [B_W-1:0]        b,
   output logic signed [P_W-1:0] p,
   output logic                  done
);
   logic signed [P_W-1:0] a_ext;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         a_ext <= '0;
         p <= '0;
      end else if (start) begin
         a_ext <= {{B_W{a[A_W-1]}}, a};
         p <= '0;
      end else if (step && b[bit_idx])
         p <= p + (a_ext <<< bit_idx);
   assign done = step && bit_idx == C_W'(B_W - 1);
endmodule

// File: rtl/audio_gain_sequencer.sv
// audio_gain_sequencer: reads a stereo codec sample, scales it by an 8-bit gain, saturates and writes it back
//   CLOCK_50, resetn (async, active-low); codec: audio_gain_sequencer_if.master
//   gain, bypass in; clip (last written pair saturated), busy (not IDLE) out
//   AUDIO_GAIN_SMOOTH_EN: effective gain walks toward gain by +-1 per sample
module audio_gain_sequencer #(
   parameter int SAMPLE_W = audio_pkg::SAMPLE_W,
   parameter int GAIN_W = audio_pkg::GAIN_W,
   parameter int GAIN_SHIFT = audio_pkg::GAIN_SHIFT
) (
   input  logic                    CLOCK_50,
   input  logic                    resetn,
   audio_gain_sequencer_if.master  codec,
   input  logic [GAIN_W-1:0]       gain,
   input  logic                    bypass,
   output logic                    clip,
   output logic                    busy
);
   import audio_pkg::*;
   localparam int ACC_W = SAMPLE_W + GAIN_W;
   localparam int CNT_W = $clog2(GAIN_W);
   localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1 << GAIN_SHIFT);
   seq_state_t state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic [GAIN_W-1:0] mul_gain, eff_nx;
   logic signed [ACC_W-1:0] acc_l, acc_r;
   logic [SAMPLE_W-1:0] sat_l, sat_r, pend_l, pend_r, out_l, out_r;
   logic clip_l, clip_r, pend_clip, out_clip, done_l, done_r, step, latch, wr;
`ifdef AUDIO_GAIN_SMOOTH_EN
   logic [GAIN_W-1:0] eff;
   assign eff_nx = gain > eff ? eff + 1'b1 : gain < eff ? eff - 1'b1 : eff;
   // bypass leaves the smoothed gain where it was
   always_ff @(posedge CLOCK_50 or negedge resetn)
      if (!resetn) eff <= UNITY;
      else if (latch && !bypass) eff <= eff_nx;
`else
   assign eff_nx = gain;
`endif
   always_ff @(posedge CLOCK_50 or negedge resetn)
      if (!resetn) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (codec.read_ready && codec.write_ready) state_nx = READ;
         READ: state_nx = MUL;
         MUL: if (done_l && done_r) state_nx = SAT;
         SAT: state_nx = WRITE;
         WRITE: if (codec.write_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // writedata/clip switch to the pending pair in the very cycle write pulses
   always_comb begin
      wr = state == WRITE && codec.write_ready;
      codec.read = state == READ;
      codec.write = wr;
      step = state == MUL;
      busy = state != IDLE;
      latch = state == IDLE && state_nx == READ;
      codec.writedata_left = wr ? pend_l : out_l;
      codec.writedata_right = wr ? pend_r : out_r;
      clip = wr ? pend_clip : out_clip;
      {clip_l, sat_l} = saturate(acc_l);
      {clip_r, sat_r} = saturate(acc_r);
   end
   always_ff @(posedge CLOCK_50 or negedge resetn)
      if (!resetn) begin
         cnt <= '0;
         mul_gain <= UNITY;
         pend_l <= '0;
         pend_r <= '0;
         pend_clip <= 1'b0;
         out_l <= '0;
         out_r <= '0;
         out_clip <= 1'b0;
      end else begin
         cnt <= step ? cnt + 1'b1 : '0;
         if (latch) mul_gain <= bypass ? UNITY : eff_nx;
         if (state == SAT) begin
            pend_l <= sat_l;
            pend_r <= sat_r;
            pend_clip <= clip_l | clip_r;
         end
         if (wr) begin
            out_l <= pend_l;
            out_r <= pend_r;
            out_clip <= pend_clip;
         end
      end
   seq_mult #(.A_W(SAMPLE_W), .B_W(GAIN_W)) u_mult_l (
      .clk(CLOCK_50), .rst_n(resetn), .start(codec.read), .step(step), .bit_idx(cnt),
      .a(codec.readdata_left), .b(mul_gain), .p(acc_l), .done(done_l));
   seq_mult #(.A_W(SAMPLE_W), .B_W(GAIN_W)) u_mult_r (
      .clk(CLOCK_50), .rst_n(resetn), .start(codec.read), .step(step), .bit_idx(cnt),
      .a(codec.readdata_right), .b(mul_gain), .p(acc_r), .done(done_r));
endmodule
